// File: rtl/bus_cfg_pkg.sv
// Shared types and constants for the bus configuration sequencer.
package bus_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    K_LOAD  = 3'd1,
    K_WAIT  = 3'd2,
    T_FLUSH = 3'd3,
    T_WAIT  = 3'd4,
    STREAM  = 3'd5,
    ERR     = 3'd6
  } seq_state_t;

  // Bus ID that addresses no column: MSB set, all other bits clear.
  function automatic logic [7:0] idle_id(input int unsigned idw);
    return 8'(8'd1 << (idw - 1));
  endfunction

endpackage

// File: rtl/busy_wait_timer.sv
// Saturating wait-cycle counter shared by the kernel and tag busy waits.
module busy_wait_timer #(
  parameter  int unsigned LIMIT = 255,
  localparam int unsigned TW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic first
);

  logic [TW-1:0] count;

  // Count cycles spent waiting; holds at LIMIT instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != TW'(LIMIT))) begin
      count <= count + TW'(1);
    end
  end

  // expired is high on the LIMIT-th waiting cycle, so the wait lasts LIMIT cycles.
  assign expired = en && (count >= TW'(LIMIT - 1));
  assign first   = (count == '0);

endmodule

// File: rtl/bus_cfg_sequencer.sv
// Bus-side master: loads kernel size, re-arms tag match, then streams ID-tagged words.
module bus_cfg_sequencer
  import bus_cfg_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 16,
  parameter  int unsigned NUM_COL      = 4,
  parameter  int unsigned BUSY_TIMEOUT = 255,
  localparam int unsigned IDW          = $clog2(NUM_COL) + 1,
  localparam int unsigned PW           = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [7:0]            cfg_kernel_size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_ifmap,
  input  logic [DATA_WIDTH-1:0] in_fltr,
  input  logic [PW-1:0]         in_psum,
  input  logic [IDW-1:0]        in_id,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] ifmap_data_B2M,
  output logic [DATA_WIDTH-1:0] fltr_data_B2M,
  output logic [PW-1:0]         psum_data_B2M,
  output logic [IDW-1:0]        ID,
  output logic                  flush_tag,
  input  logic                  tag_busy,
  output logic                  flush_kernel,
  input  logic                  kernel_busy,
  output logic [7:0]            kernel_size,
  input  logic [PW-1:0]         psum_data_M2B,
  input  logic                  VALID,
  output logic                  out_valid,
  output logic [PW-1:0]         out_psum,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [IDW-1:0] IDLE_ID = IDW'(idle_id(IDW));

  seq_state_t            state, state_d;
  logic [7:0]            kernel_size_d;
  logic                  err_d, done_d, flush_kernel_d, flush_tag_d;
  logic [IDW-1:0]        id_d;
  logic [DATA_WIDTH-1:0] ifmap_d, fltr_d;
  logic [PW-1:0]         psum_d, out_psum_d;
  logic                  waiting, expired, first;

  assign waiting  = (state == K_WAIT) || (state == T_WAIT);
  assign in_ready = (state == STREAM);
  assign busy     = (state != IDLE) && (state != ERR);

  busy_wait_timer #(.LIMIT(BUSY_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired),
    .first   (first)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    kernel_size_d = kernel_size;
    err_d         = err;
    done_d        = 1'b0;
    id_d          = IDLE_ID;
    ifmap_d       = ifmap_data_B2M;
    fltr_d        = fltr_data_B2M;
    psum_d        = psum_data_B2M;
    out_psum_d    = VALID ? psum_data_M2B : out_psum;

    case (state)
      IDLE, ERR: begin
        if (cfg_start) begin
          state_d       = K_LOAD;
          kernel_size_d = cfg_kernel_size;
          err_d         = 1'b0;
        end
      end
      K_LOAD:  state_d = K_WAIT;
      K_WAIT: begin
        if (!first && !kernel_busy) begin
          state_d = T_FLUSH;
        end else if (expired) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      T_FLUSH: state_d = T_WAIT;
      T_WAIT: begin
        if (!first && !tag_busy) begin
          state_d = STREAM;
        end else if (expired) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      STREAM: begin
        if (in_valid) begin
          id_d    = in_id;
          ifmap_d = in_ifmap;
          fltr_d  = in_fltr;
          psum_d  = in_psum;
          if (in_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    flush_kernel_d = (state_d == K_LOAD);
    flush_tag_d    = (state_d == T_FLUSH);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      kernel_size    <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
      ID             <= IDLE_ID;
      ifmap_data_B2M <= '0;
      fltr_data_B2M  <= '0;
      psum_data_B2M  <= '0;
      flush_kernel   <= 1'b0;
      flush_tag      <= 1'b0;
      out_valid      <= 1'b0;
      out_psum       <= '0;
    end else begin
      state          <= state_d;
      kernel_size    <= kernel_size_d;
      err            <= err_d;
      done           <= done_d;
      ID             <= id_d;
      ifmap_data_B2M <= ifmap_d;
      fltr_data_B2M  <= fltr_d;
      psum_data_B2M  <= psum_d;
      flush_kernel   <= flush_kernel_d;
      flush_tag      <= flush_tag_d;
      out_valid      <= VALID;
      out_psum       <= out_psum_d;
    end
  end

endmodule

// File: tb/tb_bus_cfg_sequencer.sv
// Directed self-checking bench for bus_cfg_sequencer.
module tb_bus_cfg_sequencer;

  localparam int unsigned DW  = 16;
  localparam int unsigned IDW = 3;
  localparam int unsigned PW  = 32;
  localparam int unsigned TO  = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start;
  logic [7:0]     cfg_kernel_size;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_ifmap, in_fltr;
  logic [PW-1:0]  in_psum;
  logic [IDW-1:0] in_id;
  logic           in_last;
  logic [DW-1:0]  ifmap_data_B2M, fltr_data_B2M;
  logic [PW-1:0]  psum_data_B2M;
  logic [IDW-1:0] ID;
  logic           flush_tag, tag_busy, flush_kernel, kernel_busy;
  logic [7:0]     kernel_size;
  logic [PW-1:0]  psum_data_M2B;
  logic           VALID, out_valid;
  logic [PW-1:0]  out_psum;
  logic           busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  bus_cfg_sequencer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_kernel_size(cfg_kernel_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifmap(in_ifmap), .in_fltr(in_fltr),
    .in_psum(in_psum), .in_id(in_id), .in_last(in_last),
    .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M),
    .psum_data_B2M(psum_data_B2M), .ID(ID), .flush_tag(flush_tag), .tag_busy(tag_busy),
    .flush_kernel(flush_kernel), .kernel_busy(kernel_busy), .kernel_size(kernel_size),
    .psum_data_M2B(psum_data_M2B), .VALID(VALID), .out_valid(out_valid),
    .out_psum(out_psum), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [IDW-1:0] id, input logic last);
    in_valid = 1'b1;
    in_id    = id;
    in_last  = last;
    in_ifmap = DW'(16'h1100 + 16'(id));
    in_fltr  = DW'(16'h2200 + 16'(id));
    in_psum  = PW'(32'h3333_0000 + 32'(id));
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_kernel_size = 8'd0;
    in_valid = 1'b0; in_ifmap = '0; in_fltr = '0; in_psum = '0; in_id = '0; in_last = 1'b0;
    tag_busy = 1'b0; kernel_busy = 1'b0; psum_data_M2B = '0; VALID = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_id", 64'(ID), 64'h4);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ksize", 64'(kernel_size), 64'd0);
    check("rst_flush", 64'({flush_kernel, flush_tag}), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ifmap", 64'(ifmap_data_B2M), 64'd0);
    rst = 1'b0;
    tick();

    // Nominal configure: kernel size 3
    cfg_start = 1'b1; cfg_kernel_size = 8'd3;
    tick();
    check("kload_flush_kernel", 64'(flush_kernel), 64'd1);
    check("kload_ksize", 64'(kernel_size), 64'd3);
    check("kload_busy", 64'(busy), 64'd1);
    cfg_start = 1'b0; kernel_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("kwait%0d_flush_kernel", i), 64'(flush_kernel), 64'd0);
      check($sformatf("kwait%0d_flush_tag", i), 64'(flush_tag), 64'd0);
    end
    kernel_busy = 1'b0;
    tick();
    check("tflush_flush_tag", 64'(flush_tag), 64'd1);
    check("tflush_in_ready", 64'(in_ready), 64'd0);
    tag_busy = 1'b1;
    tick();
    check("twait1_flush_tag", 64'(flush_tag), 64'd0);
    check("twait1_in_ready", 64'(in_ready), 64'd0);
    // Ignored start plus return-path beat during T_WAIT
    cfg_start = 1'b1; cfg_kernel_size = 8'd9;
    VALID = 1'b1; psum_data_M2B = 32'h0001_0002;
    tick();
    check("ignored_start_ksize", 64'(kernel_size), 64'd3);
    check("ignored_start_flush", 64'(flush_kernel), 64'd0);
    check("twait_out_valid", 64'(out_valid), 64'd1);
    check("twait_out_psum", 64'(out_psum), 64'h0001_0002);
    check("twait2_in_ready", 64'(in_ready), 64'd0);
    cfg_start = 1'b0; VALID = 1'b0; psum_data_M2B = '0; tag_busy = 1'b0;
    tick();
    check("stream_in_ready", 64'(in_ready), 64'd1);
    check("stream_out_valid_drop", 64'(out_valid), 64'd0);
    check("stream_ksize", 64'(kernel_size), 64'd3);

    // Stream IDs 0,1, bubble, 2, 3(last)
    drive_word(3'd0, 1'b0);
    tick();
    check("w0_id", 64'(ID), 64'd0);
    check("w0_ifmap", 64'(ifmap_data_B2M), 64'h1100);
    check("w0_fltr", 64'(fltr_data_B2M), 64'h2200);
    check("w0_psum", 64'(psum_data_B2M), 64'h3333_0000);
    check("w0_done", 64'(done), 64'd0);
    drive_word(3'd1, 1'b0);
    tick();
    check("w1_id", 64'(ID), 64'd1);
    check("w1_ifmap", 64'(ifmap_data_B2M), 64'h1101);
    in_valid = 1'b0;
    VALID = 1'b1; psum_data_M2B = 32'h0001_0002;
    tick();
    check("bubble_id", 64'(ID), 64'h4);
    check("bubble_ifmap_hold", 64'(ifmap_data_B2M), 64'h1101);
    check("stream_out_valid", 64'(out_valid), 64'd1);
    check("stream_out_psum", 64'(out_psum), 64'h0001_0002);
    VALID = 1'b0; psum_data_M2B = '0;
    drive_word(3'd2, 1'b0);
    tick();
    check("w2_id", 64'(ID), 64'd2);
    check("w2_out_valid", 64'(out_valid), 64'd0);
    check("w2_done", 64'(done), 64'd0);
    drive_word(3'd3, 1'b1);
    tick();
    check("w3_id", 64'(ID), 64'd3);
    check("w3_psum", 64'(psum_data_B2M), 64'h3333_0003);
    check("w3_done", 64'(done), 64'd1);
    check("w3_busy", 64'(busy), 64'd0);
    check("w3_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("post_done", 64'(done), 64'd0);
    check("post_id", 64'(ID), 64'h4);

    // Timeout on kernel_busy held high
    cfg_start = 1'b1; cfg_kernel_size = 8'd5;
    tick();
    cfg_start = 1'b0; kernel_busy = 1'b1;
    for (int i = 0; i < TO; i++) tick();
    check("to_last_wait_err", 64'(err), 64'd0);
    check("to_last_wait_busy", 64'(busy), 64'd1);
    tick();
    check("to_err", 64'(err), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_id", 64'(ID), 64'h4);
    check("to_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("to_err_sticky", 64'(err), 64'd1);
    kernel_busy = 1'b0;
    cfg_start = 1'b1; cfg_kernel_size = 8'd7;
    tick();
    check("restart_err_clr", 64'(err), 64'd0);
    check("restart_ksize", 64'(kernel_size), 64'd7);
    check("restart_flush_kernel", 64'(flush_kernel), 64'd1);
    cfg_start = 1'b0;

    // Bounded wait for STREAM, then reset mid-stream
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      tick();
    end
    check("restart_reach_stream", 64'(in_ready), 64'd1);
    drive_word(3'd2, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_id", 64'(ID), 64'h4);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ksize", 64'(kernel_size), 64'd0);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("postrst_id", 64'(ID), 64'h4);
    check("postrst_done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
